// File: rtl/spi_master_if.sv
// Byte-stream and SPI pin bundle for spi_master.
// master: the SPI initiator's view; slave: the byte source/sink and MISO driver.
interface spi_master_if;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       sck;
  logic       mosi;
  logic       miso;
  logic       ssel;

  modport master (
    input  tx_data, tx_last, tx_valid, miso,
    output tx_ready, rx_data, rx_valid, busy, sck, mosi, ssel
  );

  modport slave (
    output tx_data, tx_last, tx_valid, miso,
    input  tx_ready, rx_data, rx_valid, busy, sck, mosi, ssel
  );
endinterface

// File: rtl/spi_master.sv
// SPI mode-0 initiator, MSB first, 8-bit frames, SSEL held across bytes until TX_LAST.
// Optional SPI_MASTER_LOOPBACK_EN: receive shift register samples MOSI instead of MISO.
module spi_master #(
  parameter int CLK_DIV = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  spi_master_if.master  bus_io
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOW, S_HIGH, S_WAIT, S_HOLD, S_GAP} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      txsh_q, txsh_d;
  logic            last_q, last_d;
  logic [7:0]      rxsh_q, rxsh_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            rx_bit;
  logic            accept, cnt_done, high_end;

`ifdef SPI_MASTER_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = bus_io.miso;
  assign rx_bit      = txsh_q[7];
`else
  assign rx_bit = bus_io.miso;
`endif

  assign accept   = bus_io.tx_valid && bus_io.tx_ready;
  assign cnt_done = (cnt_q == CNT_MAX);
  assign high_end = (state_q == S_HIGH) && cnt_done;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      txsh_q     <= '0;
      last_q     <= 1'b0;
      rxsh_q     <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      txsh_q     <= txsh_d;
      last_q     <= last_d;
      rxsh_q     <= rxsh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    txsh_d     = txsh_q;
    last_d     = last_q;
    rxsh_d     = rxsh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    unique case (state_q)
      S_IDLE, S_WAIT: if (accept) state_d = S_LOW;
      S_LOW:          if (cnt_done) state_d = S_HIGH;
      S_HIGH:         if (cnt_done) state_d = (bit_q != 3'd7) ? S_LOW : (last_q ? S_HOLD : S_WAIT);
      // HOLD spans two half-periods: the trailing SCK-low half, then the SSEL hold time
      S_HOLD:         if (cnt_done && bit_q[0]) state_d = S_GAP;
      S_GAP:          if (cnt_done) state_d = S_IDLE;
      default:        state_d = S_IDLE;
    endcase
    cnt_d = (state_d != state_q || cnt_done) ? '0 : cnt_q + 1'b1;
    if (accept) begin
      txsh_d = bus_io.tx_data;
      last_d = bus_io.tx_last;
      bit_d  = 3'd0;
    end
    if (high_end) begin
      rxsh_d = {rxsh_q[6:0], rx_bit};
      bit_d  = bit_q + 3'd1;
      // MOSI keeps bit 0 after the final HIGH so the line does not glitch
      if (bit_q != 3'd7) txsh_d = {txsh_q[6:0], 1'b0};
      else begin
        rx_data_d  = {rxsh_q[6:0], rx_bit};
        rx_valid_d = 1'b1;
      end
    end
    if (state_q == S_HOLD && cnt_done) bit_d = bit_q + 3'd1;
  end

  always_comb begin
    bus_io.sck      = (state_q == S_HIGH);
    bus_io.ssel     = !(state_q inside {S_LOW, S_HIGH, S_WAIT, S_HOLD});
    bus_io.mosi     = (state_q inside {S_LOW, S_HIGH, S_WAIT, S_HOLD}) ? txsh_q[7] : 1'b0;
    bus_io.busy     = (state_q != S_IDLE);
    bus_io.tx_ready = (state_q == S_IDLE || state_q == S_WAIT) && !rst_i;
    bus_io.rx_data  = rx_data_q;
    bus_io.rx_valid = rx_valid_q;
  end
endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: slave model on the pins, per-message scoreboard, CLK_DIV=8 and CLK_DIV=2.
module tb_spi_master;
  localparam int H  = 8;
  localparam int CP = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #(CP/2) clk = ~clk;

  spi_master_if bus();
  spi_master_if bus2();

  spi_master #(.CLK_DIV(H)) dut  (.clk_i(clk), .rst_i(rst), .bus_io(bus));
  spi_master #(.CLK_DIV(2)) dut2 (.clk_i(clk), .rst_i(rst), .bus_io(bus2));

  int checks = 0;
  int passes = 0;
  int ndone  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic tmo(input string nm);
    checks++;
    $display("FAIL %s: timeout waiting on DUT", nm);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Slave model: one byte per 8 SCK falls, first bit valid as SSEL falls
  logic [7:0] sl [0:255];
  int sbit = 0, kidx = 0;
  always @(negedge bus.sck or posedge bus.ssel) begin
    if (bus.ssel === 1'b1) sbit = 0;
    else begin
      sbit++;
      if (sbit == 8) begin sbit = 0; kidx++; end
    end
  end
  assign bus.miso = (bus.ssel === 1'b1) ? 1'b0 : sl[kidx[7:0]][7-sbit];

  logic [7:0] cap;
  int cbit = 0, rises = 0;
  logic [7:0] mosi_q [$];
  always @(posedge bus.sck or posedge bus.ssel) begin
    if (bus.ssel === 1'b1) cbit = 0;
    else begin
      cap = {cap[6:0], bus.mosi};
      rises++;
      cbit++;
      if (cbit == 8) begin mosi_q.push_back(cap); cbit = 0; end
    end
  end

  logic [7:0] rx_q [$];
  int len_q [$], gap_q [$];
  int rx_cnt = 0, lowcnt = 0, gcnt = 0;
  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) begin rx_q.push_back(bus.rx_data); rx_cnt++; end
    if (bus.ssel === 1'b0) lowcnt++;
    else if (lowcnt != 0) begin len_q.push_back(lowcnt); lowcnt = 0; end
    if (bus.ssel === 1'b1 && bus.busy === 1'b1) gcnt++;
    else if (gcnt != 0) begin gap_q.push_back(gcnt); gcnt = 0; end
  end

  // Second instance (CLK_DIV=2): fixed slave byte, SCK timing monitor
  logic [7:0] sl2 = 8'h69;
  int s2bit = 0, r2n = 0, bad2 = 0;
  logic [7:0] cap2;
  time last_rise = 0;
  always @(negedge bus2.sck or posedge bus2.ssel) begin
    if (bus2.ssel === 1'b1) s2bit = 0;
    else s2bit++;
  end
  assign bus2.miso = (bus2.ssel === 1'b1 || s2bit > 7) ? 1'b0 : sl2[7-s2bit];
  always @(posedge bus2.sck) begin
    cap2 = {cap2[6:0], bus2.mosi};
    if (r2n > 0 && ($time - last_rise) != 4*CP) bad2++;
    r2n++;
    last_rise = $time;
  end
  always @(negedge bus2.sck) if (r2n > 0 && ($time - last_rise) != 2*CP) bad2++;

  function automatic logic [7:0] exp_rx(input logic [7:0] tx, input int k);
`ifdef SPI_MASTER_LOOPBACK_EN
    return tx;
`else
    return sl[k[7:0]];
`endif
  endfunction

  task automatic send(input logic [7:0] d, input logic last);
    int t = 0;
    @(negedge clk);
    bus.tx_valid = 1'b1; bus.tx_data = d; bus.tx_last = last;
    while (bus.tx_ready !== 1'b1 && t < 5000) begin @(negedge clk); t++; end
    if (bus.tx_ready !== 1'b1) begin tmo("send"); bus.tx_valid = 1'b0; return; end
    @(posedge clk); #1;
    if (last) bus.tx_valid = 1'b0;
  endtask

  task automatic finish_msg(input logic [7:0] b[$], input int exp_len, input string nm);
    int t = 0;
    int l;
    while ((len_q.size() == 0 || gap_q.size() == 0) && t < 6000) begin step(); t++; end
    if (len_q.size() == 0 || gap_q.size() == 0) begin tmo(nm); return; end
    l = len_q.pop_front();
    if (exp_len >= 0) chk({nm, " ssel_low_cycles"}, l, exp_len);
    chk({nm, " gap_cycles"}, gap_q.pop_front(), H);
    chk({nm, " ready_after_gap"}, bus.tx_ready, 1);
    for (int i = 0; i < b.size(); i++) begin
      if (mosi_q.size() == 0 || rx_q.size() == 0) tmo({nm, " byte"});
      else begin
        chk({nm, " mosi_byte"}, mosi_q.pop_front(), b[i]);
        chk({nm, " rx_byte"}, rx_q.pop_front(), exp_rx(b[i], ndone));
      end
      ndone++;
    end
  endtask

  task automatic run_msg(input logic [7:0] b[$], input int exp_len, input string nm);
    for (int i = 0; i < b.size(); i++) send(b[i], i == b.size() - 1);
    finish_msg(b, exp_len, nm);
  endtask

  typedef struct packed {
    logic [23:0] tx;   // first byte in the top octet
    logic [1:0]  nb;
    logic [15:0] len;
  } vec_t;

  initial begin
    #(CP * 90000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [5];
    logic [7:0] q [$];
    int base, bad, nb, t;

    tbl[0] = '{24'h010203, 2'd3, 16'd402};
    tbl[1] = '{24'hFF0000, 2'd2, 16'd273};
    tbl[2] = '{24'h800000, 2'd1, 16'd144};
    tbl[3] = '{24'h55AA00, 2'd2, 16'd273};
    tbl[4] = '{24'h000000, 2'd1, 16'd144};

    for (int k = 0; k < 256; k++) sl[k] = 8'($urandom);
    sl[0] = 8'h3C;
    bus.tx_valid = 0; bus.tx_data = 0; bus.tx_last = 0;
    bus2.tx_valid = 0; bus2.tx_data = 0; bus2.tx_last = 0;

    repeat (3) step();
    chk("reset sck", bus.sck, 0);
    chk("reset mosi", bus.mosi, 0);
    chk("reset ssel", bus.ssel, 1);
    chk("reset rx_data", bus.rx_data, 0);
    chk("reset rx_valid", bus.rx_valid, 0);
    chk("reset busy", bus.busy, 0);
    chk("reset tx_ready", bus.tx_ready, 0);
    @(negedge clk); rst = 1'b0;
    step();
    chk("idle tx_ready", bus.tx_ready, 1);

    // Single byte 0xA5, slave returns 0x3C
    base = rx_cnt;
    q = {8'hA5};
    run_msg(q, 18*H, "t1");
    chk("t1 rx_pulses", rx_cnt - base, 1);

    for (int v = 0; v < 5; v++) begin
      q = {};
      for (int i = 0; i < int'(tbl[v].nb); i++) q.push_back(tbl[v].tx[23-8*i -: 8]);
      base = rises;
      run_msg(q, int'(tbl[v].len), $sformatf("vec%0d", v));
      chk($sformatf("vec%0d sck_rises", v), rises - base, 8*int'(tbl[v].nb));
    end

    // Stall in WAIT_NEXT with TX_VALID low
    send(8'h11, 1'b0);
    bus.tx_valid = 1'b0;
    t = 0;
    while (bus.tx_ready !== 1'b1 && t < 400) begin step(); t++; end
    if (bus.tx_ready !== 1'b1) tmo("t3 wait_next");
    bad = 0;
    repeat (50) begin
      step();
      if (!(bus.sck === 1'b0 && bus.ssel === 1'b0 && bus.tx_ready === 1'b1)) bad++;
    end
    chk("t3 wait_next_hold_bad_cycles", bad, 0);
    send(8'hFF, 1'b1);
    q = {8'h11, 8'hFF};
    finish_msg(q, -1, "t3");

    // Reset after 3rd SCK rise of 0xC3
    base = rises;
    send(8'hC3, 1'b1);
    t = 0;
    while (rises < base + 3 && t < 400) begin @(negedge clk); t++; end
    if (rises < base + 3) tmo("t4 rises");
    base = rx_cnt;
    rst = 1'b1;
    step();
    chk("t4 abort ssel", bus.ssel, 1);
    chk("t4 abort sck", bus.sck, 0);
    chk("t4 abort mosi", bus.mosi, 0);
    @(negedge clk); rst = 1'b0;
    repeat (20) step();
    chk("t4 no rx_valid", rx_cnt - base, 0);
    chk("t4 no partial mosi byte", mosi_q.size(), 0);
    len_q.delete();
    q = {8'h5A};
    run_msg(q, 18*H, "t4 after");

    // Randomized messages
    for (int m = 0; m < 15; m++) begin
      nb = $urandom_range(1, 3);
      q = {};
      for (int i = 0; i < nb; i++) q.push_back(8'($urandom));
      repeat ($urandom_range(0, 5)) step();
      run_msg(q, nb*16*H + (nb-1) + 2*H, $sformatf("rnd%0d", m));
    end

    // CLK_DIV=2 instance
    @(negedge clk);
    bus2.tx_valid = 1'b1; bus2.tx_data = 8'h96; bus2.tx_last = 1'b1;
    step();
    bus2.tx_valid = 1'b0;
    t = 0;
    while (bus2.rx_valid !== 1'b1 && t < 200) begin step(); t++; end
    if (bus2.rx_valid !== 1'b1) tmo("t5 rx_valid");
`ifdef SPI_MASTER_LOOPBACK_EN
    chk("t5 rx_byte", bus2.rx_data, 8'h96);
`else
    chk("t5 rx_byte", bus2.rx_data, 8'h69);
`endif
    chk("t5 mosi_byte", cap2, 8'h96);
    chk("t5 sck_rises", r2n, 8);
    chk("t5 sck_timing_bad", bad2, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
